// File: rtl/risc_mem_responder_pkg.sv
// Shared address map and TMR_CTRL bit positions for the processor-side
// memory responder and its timer.
package risc_mem_responder_pkg;

  localparam logic [15:0] ADDR_LED       = 16'hFF00;
  localparam logic [15:0] ADDR_SW        = 16'hFF01;
  localparam logic [15:0] ADDR_CYCLE     = 16'hFF02;
  localparam logic [15:0] ADDR_TMR_CTRL  = 16'hFF03;
  localparam logic [15:0] ADDR_TMR_LOAD  = 16'hFF04;
  localparam logic [15:0] ADDR_TMR_COUNT = 16'hFF05;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AR   = 1;
  localparam int CTRL_IE   = 2;
  localparam int CTRL_FLAG = 15;

endpackage

// File: rtl/risc_mem_responder_timer.sv
// Down-counting timer with one-shot / auto-reload modes and a sticky
// expiry flag that software clears by writing 1 to bit 15.
module mem_timer
  import risc_mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_ctrl,
  input  logic        wr_load,
  input  logic [15:0] wdata,
  output logic [15:0] ctrl,
  output logic [15:0] load,
  output logic [15:0] count,
  output logic        irq
);

  logic        en_r, ar_r, ie_r, flag_r, irq_r;
  logic [15:0] load_r, count_r;
  logic        en_s, ar_s, ie_s, flag_s, expire_s;
  logic [15:0] load_s, count_s;

  // Next-state: counting first, then software writes override enable and COUNT.
  always_comb begin
    en_s     = en_r;
    ar_s     = ar_r;
    ie_s     = ie_r;
    load_s   = load_r;
    count_s  = count_r;
    expire_s = en_r && (count_r == 16'd1);

    if (en_r && (count_r > 16'd1)) begin
      count_s = count_r - 16'd1;
    end else if (expire_s) begin
      count_s = ar_r ? load_r : 16'd0;
      en_s    = ar_r;
    end else begin
      count_s = count_r;
    end

    // Expiry set beats a simultaneous write-1-to-clear.
    flag_s = expire_s | (flag_r & ~(wr_ctrl & wdata[CTRL_FLAG]));

    if (wr_ctrl) begin
      en_s = wdata[CTRL_EN];
      ar_s = wdata[CTRL_AR];
      ie_s = wdata[CTRL_IE];
    end else begin
      ie_s = ie_r;
    end

    if (wr_load) begin
      load_s  = wdata;
      count_s = wdata;
    end else begin
      load_s = load_r;
    end
  end

  // Timer state register; irq is registered from the same next-state terms.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_r    <= 1'b0;
      ar_r    <= 1'b0;
      ie_r    <= 1'b0;
      flag_r  <= 1'b0;
      irq_r   <= 1'b0;
      load_r  <= 16'h0000;
      count_r <= 16'h0000;
    end else begin
      en_r    <= en_s;
      ar_r    <= ar_s;
      ie_r    <= ie_s;
      flag_r  <= flag_s;
      irq_r   <= flag_s & ie_s;
      load_r  <= load_s;
      count_r <= count_s;
    end
  end

  assign ctrl  = {flag_r, 12'h000, ie_r, ar_r, en_r};
  assign load  = load_r;
  assign count = count_r;
  assign irq   = irq_r;

endmodule

// File: rtl/risc_mem_responder.sv
// Zero-wait-state memory responder: word RAM plus LED, switch, cycle counter
// and timer registers, read back combinationally on D_in.
module risc_mem_responder
  import risc_mem_responder_pkg::*;
#(
  parameter int RAM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Address,
  input  logic [15:0] D_out,
  input  logic        mw_en,
  output logic [15:0] D_in,
  input  logic [7:0]  sw_in,
  output logic [7:0]  led_out,
  output logic        tmr_irq
);

  localparam int          AW        = $clog2(RAM_DEPTH);
  localparam logic [16:0] RAM_LIMIT = 17'(RAM_DEPTH);

  logic [15:0] mem [RAM_DEPTH];
  logic [7:0]  led_r, sw_meta_r, sw_sync_r;
  logic [15:0] cycle_r;
  logic [15:0] tmr_ctrl_s, tmr_load_s, tmr_count_s;
  logic        ram_hit_s;
  logic [AW-1:0] ram_idx_s;

  assign ram_hit_s = ({1'b0, Address} < RAM_LIMIT);
  assign ram_idx_s = Address[AW-1:0];

  // RAM write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mw_en && ram_hit_s) begin
      mem[ram_idx_s] <= D_out;
    end
  end

  // LED register, switch synchroniser and free-running cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_r     <= 8'h00;
      sw_meta_r <= 8'h00;
      sw_sync_r <= 8'h00;
      cycle_r   <= 16'h0000;
    end else begin
      if (mw_en && (Address == ADDR_LED)) begin
        led_r <= D_out[7:0];
      end
      sw_meta_r <= sw_in;
      sw_sync_r <= sw_meta_r;
      cycle_r   <= (mw_en && (Address == ADDR_CYCLE)) ? 16'h0000 : cycle_r + 16'd1;
    end
  end

  mem_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_ctrl (mw_en && (Address == ADDR_TMR_CTRL)),
    .wr_load (mw_en && (Address == ADDR_TMR_LOAD)),
    .wdata   (D_out),
    .ctrl    (tmr_ctrl_s),
    .load    (tmr_load_s),
    .count   (tmr_count_s),
    .irq     (tmr_irq)
  );

  // Combinational read decode; anything unmapped returns zero.
  always_comb begin
    D_in = 16'h0000;
    if (ram_hit_s) begin
      D_in = mem[ram_idx_s];
    end else begin
      case (Address)
        ADDR_LED:       D_in = {8'h00, led_r};
        ADDR_SW:        D_in = {8'h00, sw_sync_r};
        ADDR_CYCLE:     D_in = cycle_r;
        ADDR_TMR_CTRL:  D_in = tmr_ctrl_s;
        ADDR_TMR_LOAD:  D_in = tmr_load_s;
        ADDR_TMR_COUNT: D_in = tmr_count_s;
        default:        D_in = 16'h0000;
      endcase
    end
  end

  assign led_out = led_r;

endmodule

// File: tb/tb_risc_mem_responder.sv
// Directed bench: a vector table for the address map, then hand sequences
// for timer, cycle counter, synchroniser and asynchronous reset.
module tb_risc_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] Address;
  logic [15:0] D_out;
  logic        mw_en;
  logic [15:0] D_in;
  logic [7:0]  sw_in;
  logic [7:0]  led_out;
  logic        tmr_irq;

  int tests = 0;
  int fails = 0;

  risc_mem_responder #(.RAM_DEPTH(1024)) dut (
    .clk     (clk),
    .reset   (reset),
    .Address (Address),
    .D_out   (D_out),
    .mw_en   (mw_en),
    .D_in    (D_in),
    .sw_in   (sw_in),
    .led_out (led_out),
    .tmr_irq (tmr_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        chk;
    logic [15:0] exp_d;
    logic [7:0]  exp_led;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    Address = addr;
    D_out   = data;
    mw_en   = 1'b1;
    step();
    mw_en   = 1'b0;
  endtask

  task automatic rd(input string name, input logic [15:0] addr, input logic [15:0] exp);
    Address = addr;
    #1;
    check(name, D_in, exp);
  endtask

  initial begin
    vecs[0]  = '{16'h0010, 16'h1234, 1'b1, 1'b0, 16'h0000, 8'h00};
    vecs[1]  = '{16'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234, 8'h00};
    vecs[2]  = '{16'h8000, 16'h0000, 1'b0, 1'b1, 16'h0000, 8'h00};
    vecs[3]  = '{16'hFF00, 16'h01A5, 1'b1, 1'b1, 16'h0000, 8'h00};
    vecs[4]  = '{16'hFF00, 16'h0000, 1'b0, 1'b1, 16'h00A5, 8'hA5};
    vecs[5]  = '{16'h03FF, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 8'hA5};
    vecs[6]  = '{16'h03FF, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 8'hA5};
    vecs[7]  = '{16'h0400, 16'h0000, 1'b0, 1'b1, 16'h0000, 8'hA5};
    vecs[8]  = '{16'hFF06, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 8'hA5};
    vecs[9]  = '{16'hFF06, 16'h0000, 1'b0, 1'b1, 16'h0000, 8'hA5};
    vecs[10] = '{16'hFF01, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 8'hA5};
    vecs[11] = '{16'hFF01, 16'h0000, 1'b0, 1'b1, 16'h0000, 8'hA5};
    vecs[12] = '{16'hFF05, 16'h1234, 1'b1, 1'b1, 16'h0000, 8'hA5};
    vecs[13] = '{16'hFF05, 16'h0000, 1'b0, 1'b1, 16'h0000, 8'hA5};
    vecs[14] = '{16'hFF03, 16'h7FF8, 1'b1, 1'b1, 16'h0000, 8'hA5};
    vecs[15] = '{16'hFF03, 16'h0000, 1'b0, 1'b1, 16'h0000, 8'hA5};
    vecs[16] = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 8'hA5};
    vecs[17] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 8'hA5};
    vecs[18] = '{16'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234, 8'hA5};
    vecs[19] = '{16'hFF04, 16'h0000, 1'b0, 1'b1, 16'h0000, 8'hA5};

    reset   = 1'b1;
    Address = 16'hFF02;
    D_out   = 16'h0000;
    mw_en   = 1'b0;
    sw_in   = 8'h00;
    repeat (3) step();
    check("reset_led", {8'h00, led_out}, 16'h0000);
    check("reset_irq", {15'h0000, tmr_irq}, 16'h0000);
    rd("reset_cycle", 16'hFF02, 16'h0000);
    reset = 1'b0;
    step();

    for (int i = 0; i < 20; i++) begin
      Address = vecs[i].addr;
      D_out   = vecs[i].wdata;
      mw_en   = vecs[i].we;
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d_d_in", i), D_in, vecs[i].exp_d);
      check($sformatf("vec%0d_led", i), {8'h00, led_out}, {8'h00, vecs[i].exp_led});
      step();
    end
    mw_en = 1'b0;

    // One-shot timer: 3,2,1,0 then FLAG with irq
    wr(16'hFF04, 16'd3);
    rd("os_load_copy", 16'hFF05, 16'd3);
    wr(16'hFF03, 16'h0005);
    rd("os_c3", 16'hFF05, 16'd3);
    step();
    rd("os_c2", 16'hFF05, 16'd2);
    step();
    rd("os_c1", 16'hFF05, 16'd1);
    check("os_irq_low", {15'h0000, tmr_irq}, 16'h0000);
    step();
    rd("os_c0", 16'hFF05, 16'd0);
    rd("os_ctrl", 16'hFF03, 16'h8004);
    check("os_irq_high", {15'h0000, tmr_irq}, 16'h0001);
    step();
    rd("os_hold", 16'hFF05, 16'd0);
    wr(16'hFF03, 16'h8005);
    rd("zero_ctrl", 16'hFF03, 16'h0005);
    check("zero_irq", {15'h0000, tmr_irq}, 16'h0000);
    step();
    rd("zero_noflag", 16'hFF03, 16'h0005);
    rd("zero_count", 16'hFF05, 16'd0);

    // Auto-reload and write/expiry collisions
    wr(16'hFF03, 16'h0000);
    wr(16'hFF04, 16'd2);
    wr(16'hFF03, 16'h0003);
    rd("ar_c2a", 16'hFF05, 16'd2);
    step();
    rd("ar_c1a", 16'hFF05, 16'd1);
    step();
    rd("ar_c2b", 16'hFF05, 16'd2);
    rd("ar_flag", 16'hFF03, 16'h8003);
    wr(16'hFF03, 16'h8003);
    rd("ar_clear", 16'hFF03, 16'h0003);
    rd("ar_c1b", 16'hFF05, 16'd1);
    wr(16'hFF03, 16'h8003);
    rd("ar_set_wins", 16'hFF03, 16'h8003);
    rd("ar_reload", 16'hFF05, 16'd2);
    step();
    rd("ar_c1c", 16'hFF05, 16'd1);
    wr(16'hFF04, 16'd7);
    rd("load_wins", 16'hFF05, 16'd7);
    rd("load_flag", 16'hFF03, 16'h8003);
    wr(16'hFF04, 16'd1);
    rd("load_one", 16'hFF05, 16'd1);
    wr(16'hFF03, 16'h0000);
    rd("en_write_wins", 16'hFF03, 16'h8000);
    rd("en_reload", 16'hFF05, 16'd1);
    step();
    rd("dis_hold", 16'hFF05, 16'd1);

    // Cycle counter clear, count and wrap
    wr(16'hFF02, 16'h0000);
    rd("cyc_clr0", 16'hFF02, 16'h0000);
    repeat (5) step();
    rd("cyc_5", 16'hFF02, 16'h0005);
    wr(16'hFF02, 16'hABCD);
    rd("cyc_wr_wins", 16'hFF02, 16'h0000);
    step();
    rd("cyc_1", 16'hFF02, 16'h0001);
    repeat (65534) step();
    rd("cyc_ffff", 16'hFF02, 16'hFFFF);
    step();
    rd("cyc_wrap", 16'hFF02, 16'h0000);

    // Switch synchroniser latency
    sw_in = 8'h3C;
    rd("sw_0", 16'hFF01, 16'h0000);
    step();
    rd("sw_1", 16'hFF01, 16'h0000);
    step();
    rd("sw_2", 16'hFF01, 16'h003C);

    // Asynchronous reset in the middle of a count
    wr(16'hFF00, 16'h005A);
    wr(16'hFF04, 16'd100);
    wr(16'hFF03, 16'h0001);
    step();
    rd("pre_rst_count", 16'hFF05, 16'd99);
    check("pre_rst_led", {8'h00, led_out}, 16'h005A);
    reset = 1'b1;
    rd("rst_count", 16'hFF05, 16'd0);
    check("rst_led", {8'h00, led_out}, 16'h0000);
    check("rst_irq", {15'h0000, tmr_irq}, 16'h0000);
    step();
    reset = 1'b0;
    step();
    rd("post_rst_count", 16'hFF05, 16'd0);
    rd("post_rst_ctrl", 16'hFF03, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
